// File: rtl/t07_tft_arbiter_if.sv
// rtl/t07_tft_arbiter_if.sv - requester and serializer signals of the TFT arbiter
// slave is the arbiter side; master is the requesters plus serializer side.
interface t07_tft_arbiter_if;
  logic [1:0]  req_valid_i;
  logic [31:0] req_addr0_i;
  logic [31:0] req_addr1_i;
  logic [31:0] req_data0_i;
  logic [31:0] req_data1_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  done_o;
  logic        err_o;
  logic        spi_wi_o;
  logic [31:0] spi_addr_o;
  logic [31:0] spi_data_o;
  logic        spi_busy_i;

  modport slave (
    input  req_valid_i, req_addr0_i, req_addr1_i, req_data0_i, req_data1_i, spi_busy_i,
    output req_ready_o, done_o, err_o, spi_wi_o, spi_addr_o, spi_data_o
  );

  modport master (
    output req_valid_i, req_addr0_i, req_addr1_i, req_data0_i, req_data1_i, spi_busy_i,
    input  req_ready_o, done_o, err_o, spi_wi_o, spi_addr_o, spi_data_o
  );
endinterface

// File: rtl/t07_tft_arbiter.sv
// rtl/t07_tft_arbiter.sv - round-robin arbiter sharing one SPI TFT serializer
// Two requesters, one payload in flight, launch timeout and enforced inter-transfer gap.
module t07_tft_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst,
  t07_tft_arbiter_if.slave bus
);
  localparam int MAXC = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, GAP} state_t;

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] data_q, data_nx;
  logic [1:0]  done_q, done_nx;
  logic        err_q, err_nx;
  logic [1:0]  grant;
  logic        winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      last   <= last_nx;
      cnt    <= cnt_nx;
      addr_q <= addr_nx;
      data_q <= data_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    data_nx  = data_q;
    done_nx  = 2'b00;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          state_nx = LAUNCH;
          owner_nx = winner;
          last_nx  = winner;
          cnt_nx   = '0;
          addr_nx  = winner ? bus.req_addr1_i : bus.req_addr0_i;
          data_nx  = winner ? bus.req_data1_i : bus.req_data0_i;
        end
      end
      LAUNCH: begin
        cnt_nx = cnt + CW'(1);
        // A busy edge on the final allowed cycle still counts as an acknowledge.
        if (bus.spi_busy_i) begin
          state_nx = ACTIVE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = GAP;
        end
      end
      ACTIVE: begin
        if (!bus.spi_busy_i) begin
          done_nx  = owner ? 2'b10 : 2'b01;
          cnt_nx   = '0;
          state_nx = GAP;
        end
      end
      GAP: begin
        cnt_nx = cnt + CW'(1);
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant  = 2'b00;
    winner = 1'b0;
    // A stale busy from the serializer blocks any new grant.
    if (state == IDLE && !rst && !bus.spi_busy_i) begin
      case (bus.req_valid_i)
        2'b01: begin
          grant  = 2'b01;
          winner = 1'b0;
        end
        2'b10: begin
          grant  = 2'b10;
          winner = 1'b1;
        end
        2'b11: begin
          winner = ~last;
          grant  = last ? 2'b01 : 2'b10;
        end
        default: begin
          grant  = 2'b00;
          winner = 1'b0;
        end
      endcase
    end
    bus.req_ready_o = grant;
    bus.spi_wi_o    = (state == LAUNCH) || (state == ACTIVE);
  end

  assign bus.spi_addr_o = addr_q;
  assign bus.spi_data_o = data_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_t07_tft_arbiter.sv
// tb/tb_t07_tft_arbiter.sv - scoreboard bench for t07_tft_arbiter
// Stimulus queues expected grants and completions; a negedge monitor pops and compares.
module tb_t07_tft_arbiter;
  localparam int LIMIT = 300;
  localparam logic [31:0] A0 = 32'h0000_0040;
  localparam logic [31:0] D0 = 32'hDEAD_BEEF;
  localparam logic [31:0] A1 = 32'h0000_0080;
  localparam logic [31:0] D1 = 32'h1234_5678;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } gnt_t;

  logic clk;
  logic rst;
  t07_tft_arbiter_if bus();

  t07_tft_arbiter #(.GAP_CYCLES(2), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  gnt_t grant_q[$];
  logic [2:0] comp_q[$];

  int   wcnt = 0;
  int   dly = 2;
  logic force_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Serializer model: busy rises once wi has been high dly+1 cycles and stays 65 cycles.
  initial begin
    bus.spi_busy_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.spi_wi_o === 1'b1) wcnt++;
      else wcnt = 0;
      bus.spi_busy_i = force_busy || (wcnt >= dly + 1 && wcnt <= dly + 65);
    end
  end

  // Monitor
  initial begin
    logic        cap_pend = 1'b0;
    logic        prev_pulse = 1'b0;
    gnt_t        g;
    logic [2:0]  c;
    logic [31:0] ea, ed;
    forever begin
      @(negedge clk);
      if (cap_pend) begin
        check("cap_addr", bus.spi_addr_o, ea);
        check("cap_data", bus.spi_data_o, ed);
        check("cap_wi", bus.spi_wi_o, 1);
        cap_pend = 1'b0;
      end
      if (bus.req_ready_o != 2'b00) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", bus.req_ready_o, 0);
        end else begin
          g = grant_q.pop_front();
          check("grant", bus.req_ready_o, g.sel);
          ea = g.addr;
          ed = g.data;
          cap_pend = 1'b1;
        end
      end
      if (bus.done_o != 2'b00 || bus.err_o == 1'b1) begin
        check("pulse_width", prev_pulse, 0);
        if (comp_q.size() == 0) begin
          check("unexpected_comp", {bus.done_o, bus.err_o}, 0);
        end else begin
          c = comp_q.pop_front();
          check("comp", {bus.done_o, bus.err_o}, c);
        end
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.req_ready_o != 2'b00) return;
      if (n >= LIMIT) begin
        check("ready_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic wait_comp(output int hi);
    int n = 0;
    hi = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.done_o != 2'b00 || bus.err_o == 1'b1) begin
        check("wi_low_at_comp", bus.spi_wi_o, 0);
        return;
      end
      if (bus.spi_wi_o) hi++;
      if (n >= LIMIT) begin
        check("comp_timeout", 0, 1);
        return;
      end
    end
  endtask

  initial begin
    int n, h;
    rst = 1'b1;
    bus.req_valid_i = 2'b00;
    bus.req_addr0_i = A0;
    bus.req_data0_i = D0;
    bus.req_addr1_i = A1;
    bus.req_data1_i = D1;

    // Reset state, with ready gated while rst is high
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wi", bus.spi_wi_o, 0);
    check("rst_addr", bus.spi_addr_o, 0);
    check("rst_data", bus.spi_data_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_err", bus.err_o, 0);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b01;
    @(negedge clk);
    check("rst_ready_gated", bus.req_ready_o, 0);

    // Single write from requester 0
    grant_q.push_back('{2'b01, A0, D0});
    comp_q.push_back(3'b010);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(n);
    check("single_ready_latency", n, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    wait_comp(h);
    check("single_wi_cycles", h, 68);

    // Stale busy blocks the grant until it falls
    @(posedge clk); #1;
    force_busy = 1'b1;
    bus.req_valid_i = 2'b10;
    grant_q.push_back('{2'b10, A1, D1});
    comp_q.push_back(3'b100);
    repeat (5) begin
      @(negedge clk);
      check("stale_busy_ready", bus.req_ready_o, 0);
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    wait_ready(n);
    check("stale_release_latency", n, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    wait_comp(h);
    check("stale_wi_cycles", h, 68);

    // Contention: last=1, so the order is 0,1,0,1 with a 2-cycle gap
    @(posedge clk); #1;
    bus.req_valid_i = 2'b11;
    grant_q.push_back('{2'b01, A0, D0});
    grant_q.push_back('{2'b10, A1, D1});
    grant_q.push_back('{2'b01, A0, D0});
    grant_q.push_back('{2'b10, A1, D1});
    comp_q.push_back(3'b010);
    comp_q.push_back(3'b100);
    comp_q.push_back(3'b010);
    comp_q.push_back(3'b100);
    for (int i = 0; i < 4; i++) begin
      wait_ready(n);
      if (i > 0) check("contention_gap", n, 2);
      if (i == 3) begin
        @(posedge clk); #1;
        bus.req_valid_i = 2'b00;
      end
      wait_comp(h);
      check("contention_wi_cycles", h, 68);
    end

    // Timeout: busy never rises
    @(posedge clk); #1;
    dly = 1000;
    bus.req_valid_i = 2'b01;
    grant_q.push_back('{2'b01, A0, D0});
    comp_q.push_back(3'b001);
    wait_ready(n);
    check("timeout_gap", n, 2);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    wait_comp(h);
    check("timeout_launch_cycles", h, 16);

    // Recovery after timeout
    @(posedge clk); #1;
    dly = 2;
    bus.req_valid_i = 2'b10;
    grant_q.push_back('{2'b10, A1, D1});
    comp_q.push_back(3'b100);
    wait_ready(n);
    check("post_timeout_gap", n, 2);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    wait_comp(h);
    check("post_timeout_wi_cycles", h, 68);

    // Boundary: busy rises on the last allowed LAUNCH cycle
    @(posedge clk); #1;
    dly = 15;
    bus.req_valid_i = 2'b01;
    grant_q.push_back('{2'b01, A0, D0});
    comp_q.push_back(3'b010);
    wait_ready(n);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    wait_comp(h);
    check("boundary_wi_cycles", h, 81);

    // Reset mid-ACTIVE on a requester-0 transfer; no completion expected
    @(posedge clk); #1;
    dly = 2;
    bus.req_valid_i = 2'b01;
    grant_q.push_back('{2'b01, A0, D0});
    wait_ready(n);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    n = 0;
    while (wcnt != 33 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("reach_shift_30", wcnt, 33);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", bus.req_ready_o, 0);
    grant_q.push_back('{2'b01, A0, D0});
    comp_q.push_back(3'b010);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    check("after_rst_wi", bus.spi_wi_o, 0);
    check("after_rst_done", bus.done_o, 0);
    check("after_rst_tie", bus.req_ready_o, 2'b01);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    wait_comp(h);
    check("after_rst_wi_cycles", h, 68);

    repeat (4) @(negedge clk);
    check("grant_q_empty", grant_q.size(), 0);
    check("comp_q_empty", comp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/t07_tft_arbiter.md
# t07_tft_arbiter

Shares the single SPI TFT serializer between two requesters: requester 0 is the memory handler (CPU stores) and requester 1 is the display refresh engine. It accepts one 32-bit address/data pair at a time over a valid/ready handshake, holds the serializer's write-enable (`wi`) for the whole transfer, and detects completion from the serializer's `busy`. It enforces an inter-transaction gap and aborts transfers the serializer never acknowledges. It sits between the requesters and the serializer.

## Interface
- `GAP_CYCLES`, default 2 — cycles `spi_wi_o` is held low between transactions (≥1).
- `TIMEOUT`, default 16 — maximum cycles allowed in LAUNCH waiting for `spi_busy_i` to rise (≥4).
- `clk` in 1 — single clock, all logic on its rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `req_valid_i` in 2 — bit k: requester k has a pending write.
- `req_addr0_i`, `req_addr1_i` in 32 — address per requester.
- `req_data0_i`, `req_data1_i` in 32 — data per requester.
- `req_ready_o` out 2 — one-hot; bit k high means requester k's payload is captured this cycle.
- `done_o` out 2 — one-cycle pulse on bit k when requester k's transfer completes.
- `err_o` out 1 — one-cycle pulse when a transfer is aborted on timeout.
- `spi_wi_o` out 1 — write-enable to the serializer.
- `spi_addr_o` out 32 — address to the serializer.
- `spi_data_o` out 32 — data to the serializer.
- `spi_busy_i` in 1 — serializer busy flag.

## Operation
- States: IDLE, LAUNCH, ACTIVE, GAP. Additional registers:
  - `owner` (1b): requester of the current transfer.
  - `last` (1b): last requester granted.
  - `cnt` (5b): shared timeout/gap counter.
- IDLE:
  - `spi_wi_o`=0.
  - Grant is permitted only when `spi_busy_i`=0. If the serializer reports busy while idle, no grant is made.
  - Grant: if exactly one valid bit is set, that requester wins. If both are set, the requester ≠ `last` wins (round-robin).
  - `req_ready_o` is combinational: one-hot to the winner in IDLE, 0 in every other state.
  - On the transfer edge:
    - latch the winner's addr/data into `spi_addr_o`/`spi_data_o`;
    - set `owner` and `last` to the winner;
    - clear `cnt`;
    - go to LAUNCH.
- LAUNCH:
  - `spi_wi_o`=1, `cnt` increments.
  - `spi_busy_i`=1 → ACTIVE.
  - Otherwise, `cnt`=TIMEOUT-1 → pulse `err_o`, clear `cnt`, go to GAP. No `done_o` is issued.
- ACTIVE:
  - `spi_wi_o`=1.
  - First cycle with `spi_busy_i`=0 → pulse `done_o[owner]`, clear `cnt`, go to GAP.
  - ACTIVE has no timeout (a 64-bit shift is bounded by the serializer).
- GAP:
  - `spi_wi_o`=0, `cnt` increments.
  - `cnt`=GAP_CYCLES-1 → IDLE.
- `spi_addr_o`/`spi_data_o` hold their values from capture until the next capture.
- A requester must hold valid and payload stable until ready. Dropping valid before ready is legal; no transfer occurs.
- `cnt` width must cover max(GAP_CYCLES, TIMEOUT) − 1.

## Timing
- Reset values:
  - state=IDLE, `last`=1 (so requester 0 wins the first tie), `owner`=0, `cnt`=0.
  - `spi_wi_o`=0; `spi_addr_o`=0; `spi_data_o`=0.
  - `done_o`=0; `err_o`=0.
  - `req_ready_o`=0, because of the reset gating below.
- While `rst` is high, `req_ready_o` is forced to 0 and no capture occurs.
- Reset mid-transfer: `spi_wi_o` is low on the cycle after the reset edge. No `done_o` or `err_o` is produced for the killed transfer.
- Capture at edge T:
  - `spi_wi_o` is high from T.
  - The serializer's busy is expected at T+2.
  - Completion requires a 2-cycle minimum in LAUNCH.
- `done_o` is asserted in the cycle after the state machine samples `spi_busy_i` falling in ACTIVE. `spi_wi_o` is 0 that same cycle.
- Back-to-back throughput: next capture no earlier than GAP_CYCLES cycles after leaving ACTIVE.
- Simultaneous events:
  - A new valid arriving during LAUNCH/ACTIVE/GAP waits in IDLE arbitration; requests are never dropped.
  - Busy rising on the same cycle `cnt` reaches TIMEOUT-1: busy wins, so the transfer proceeds to ACTIVE with no error.
- `done_o` and `err_o` are never high together and each is never high for more than one cycle.

## Test plan
- Single write: `rst` for 2 cycles, then requester 0 presents addr=0x0000_0040, data=0xDEAD_BEEF. A serializer model raises busy 2 cycles after `wi` and drops it after 65 cycles. Required:
  - `req_ready_o`=01 for one cycle;
  - `spi_addr_o`/`spi_data_o` match the payload;
  - `spi_wi_o` high through completion;
  - `done_o`=01 once;
  - `spi_wi_o` low for exactly 2 cycles before the next grant.
- Contention: both requesters valid continuously for 4 transfers. Required grant order: 0, 1, 0, 1. Each `done_o` bit matches the owner of its transfer.
- Timeout: model never raises busy. Required:
  - `err_o` pulses on the 16th LAUNCH cycle;
  - no `done_o`;
  - `spi_wi_o` drops, and GAP is followed by IDLE accepting a new request.
- Stale busy: `spi_busy_i` held 1 while IDLE with requester 1 valid. Required: `req_ready_o`=00 until busy falls, then `req_ready_o`=10 on that cycle.
- Reset mid-ACTIVE: assert `rst` for 1 cycle at shift 30. Required:
  - `spi_wi_o`=0 and `done_o`=00 on the next cycle;
  - `last` reverts so requester 0 wins the next tie.
- Boundary: busy rises on the same cycle `cnt`=TIMEOUT-1. Required: `err_o` stays 0, ACTIVE is entered, and `done_o` fires normally.
